div_pipe_scheduler: RTL and testbench
=====================================

DIV_PIPE_SCHEDULER -- requirements
Module: div_pipe_scheduler

Interface
REQ-001 SHALL have parameter DIVIDENDLEN, default 16, dividend and quotient width; also the pipeline latency L.
REQ-002 SHALL have parameter DIVISORLEN, default 8, divisor and remainder width.
REQ-003 SHALL have parameter FIFODEPTH, default 4, result buffer depth and in-flight credit limit; legal values are FIFODEPTH>=1.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, as follows.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all state changes on its posedge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have ports req0_valid (input, 1 bit) and req0_ready (output, 1 bit): requester 0 handshake.
REQ-008 SHALL have ports req0_dividend (input, DIVIDENDLEN bits) and req0_divisor (input, DIVISORLEN bits): requester 0 operands.
REQ-009 SHALL have ports req1_valid, req1_ready, req1_dividend and req1_divisor: requester 1, with the same directions and widths as requester 0.
REQ-010 SHALL have ports rsp_valid (output, 1 bit) and rsp_ready (input, 1 bit): result handshake.
REQ-011 SHALL have port rsp_id, output, 1 bit: the requester that issued the head result.
REQ-012 SHALL have ports rsp_quotient (output, DIVIDENDLEN bits) and rsp_remainder (output, DIVISORLEN bits): the result data.
REQ-013 SHALL have port rsp_dz, output, 1 bit: the head result had divisor==0.
REQ-014 SHALL have port busy, output, 1 bit: high when any operation is in flight or buffered.

Function
REQ-015 SHALL instantiate one pipelinediv #(DIVIDENDLEN,DIVISORLEN); this divider has a fixed latency of L=DIVIDENDLEN posedges, has no reset and cannot stall.
REQ-016 SHALL keep an occupancy counter cnt (0..FIFODEPTH) equal to in-flight plus buffered operations; credit is available when cnt<FIFODEPTH.
REQ-017 Arbitration SHALL be round-robin using a last-grant pointer; only a valid requester is granted; when both are valid, the requester not last granted wins.
REQ-018 reqN_ready SHALL be asserted combinationally only when requester N is granted and credit is available; a request is accepted at a posedge where valid&&ready; at most one request is accepted per cycle.
REQ-019 The last-grant pointer SHALL update only on acceptance.
REQ-020 During an accepting cycle, the granted operands SHALL be muxed onto the divider inputs; otherwise the divider inputs SHALL be driven to zero.
REQ-021 SHALL keep a tag shift register of L entries {valid,id,dz}; at each posedge, entry0 <= {accept,grant_id,divisor==0} and entry k <= entry k-1.
REQ-022 When entry L-1 is valid, the divider output SHALL be pushed into the FIFO at the next posedge, together with its id and dz.
REQ-023 When dz=1, the pushed quotient SHALL be all ones and the pushed remainder SHALL be zero, overriding the divider output.
REQ-024 The FIFO SHALL be FIFODEPTH deep and first-in first-out; rsp_* SHALL present the head entry; rsp_valid = FIFO not empty; a pop SHALL occur on rsp_valid&&rsp_ready.
REQ-025 cnt SHALL be incremented on accept, decremented on pop, and left unchanged when both occur in the same cycle.
REQ-026 Credit freed by a pop SHALL be usable from the next cycle, because ready uses the registered cnt.
REQ-027 The FIFO SHALL never overflow, because cnt bounds it; a simultaneous push and pop on a full FIFO SHALL be handled correctly, with pointers wrapping modulo FIFODEPTH.
REQ-028 Acceptance-to-response latency SHALL be exactly L+1 posedges: a request accepted at edge E asserts rsp_valid after edge E+L+1, provided the FIFO was empty.
REQ-029 Results SHALL be returned in acceptance order regardless of id.
REQ-030 busy SHALL equal (cnt!=0).

Reset
REQ-031 While reset is high, all tags SHALL be invalid, the FIFO empty, cnt=0 and the last-grant pointer=1 so that req0 wins first; rsp_valid, req0_ready, req1_ready and busy SHALL be 0; rsp_quotient, rsp_remainder, rsp_id and rsp_dz SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight and buffered results; stale divider contents SHALL be ignored because the tags are cleared.
REQ-033 Normal operation SHALL resume at the first posedge after reset deasserts.

Verification
REQ-034 Apply req0 with 100/7, L=16 -> exactly one response 17 edges after acceptance with quotient=14, remainder=2, id=0, dz=0.
REQ-035 Apply req1 with 16'h1234/0 -> a response with quotient=16'hFFFF, remainder=0, dz=1, id=1.
REQ-036 Hold both requesters valid with rsp_ready=1 -> grants alternate 0,1,0,1, starting with 0 after reset.
REQ-037 With FIFODEPTH=4 and rsp_ready=0, hold both requesters valid -> exactly 4 acceptances, then both ready=0; a single pop allows exactly one further acceptance on the following cycle.
REQ-038 With the FIFO full, issue pop and accept in the same cycle -> cnt stays 4; no result is lost or duplicated; order is preserved.
REQ-039 Assert reset with 3 operations in flight and 1 buffered -> busy=0 and rsp_valid=0 immediately; no stale responses appear after reset deasserts.

Source files
------------

// File: rtl/div_pipe_scheduler.sv
// Two-requester front end for a fixed-latency pipelined divider: round-robin
// arbitration, credit-limited issue, tag tracking and an in-order result FIFO.

module pipelinediv #(
  parameter int DIVIDENDLEN = 16,
  parameter int DIVISORLEN  = 8
) (
  input  logic                   clock,
  input  logic [DIVIDENDLEN-1:0] dividend,
  input  logic [DIVISORLEN-1:0]  divisor,
  output logic [DIVIDENDLEN-1:0] quotient,
  output logic [DIVISORLEN-1:0]  remainder
);
  localparam int N = DIVIDENDLEN;
  localparam int M = DIVISORLEN;

  // One restoring-division step per stage, MSB first; quo_reg shifts dividend bits out and quotient bits in.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_stage
      logic [M-1:0] rem_reg;
      logic [N-1:0] quo_reg;
      logic [M-1:0] rem_in;
      logic [N-1:0] quo_in;
      logic [M-1:0] dsr_in;
      logic [M:0]   trial;
      logic [M-1:0] diff;
      logic         fits;

      if (gi == 0) begin : g_first
        assign rem_in = '0;
        assign quo_in = dividend;
        assign dsr_in = divisor;
      end else begin : g_rest
        assign rem_in = g_stage[gi-1].rem_reg;
        assign quo_in = g_stage[gi-1].quo_reg;
        assign dsr_in = g_stage[gi-1].g_pass.dsr_reg;
      end

      assign trial = {rem_in, quo_in[N-1]};
      assign fits  = trial >= {1'b0, dsr_in};
      assign diff  = trial[M-1:0] - dsr_in;

      always_ff @(posedge clock) begin
        rem_reg <= fits ? diff : trial[M-1:0];
        quo_reg <= N'({quo_in, fits});
      end

      if (gi < N - 1) begin : g_pass
        logic [M-1:0] dsr_reg;
        always_ff @(posedge clock) begin
          dsr_reg <= dsr_in;
        end
      end
    end
  endgenerate

  assign quotient  = g_stage[N-1].quo_reg;
  assign remainder = g_stage[N-1].rem_reg;
endmodule

module div_pipe_scheduler #(
  parameter int DIVIDENDLEN = 16,
  parameter int DIVISORLEN  = 8,
  parameter int FIFODEPTH   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [DIVIDENDLEN-1:0] req0_dividend,
  input  logic [DIVISORLEN-1:0]  req0_divisor,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [DIVIDENDLEN-1:0] req1_dividend,
  input  logic [DIVISORLEN-1:0]  req1_divisor,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [DIVIDENDLEN-1:0] rsp_quotient,
  output logic [DIVISORLEN-1:0]  rsp_remainder,
  output logic                   rsp_dz,
  output logic                   busy
);
  localparam int L  = DIVIDENDLEN;
  localparam int PW = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
  localparam int CW = $clog2(FIFODEPTH + 1);
  localparam int EW = DIVIDENDLEN + DIVISORLEN + 2;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFODEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFODEPTH - 1);

  logic                   last_reg;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic                   grant_id, credit, accept, pop, push, dz_in;
  logic [DIVIDENDLEN-1:0] div_dividend, div_quotient;
  logic [DIVISORLEN-1:0]  div_divisor, div_remainder;
  logic [L-1:0]           tag_valid_reg, tag_id_reg, tag_dz_reg;
  logic                   stg_valid_reg;
  logic [EW-1:0]          stg_entry_reg, stg_entry_next;
  logic [EW-1:0]          mem [FIFODEPTH];
  logic [PW-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]          fifo_cnt_reg;
  logic [EW-1:0]          head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // When both requesters are valid, the one not granted last time wins.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) grant_id = ~last_reg;
    else if (req1_valid)          grant_id = 1'b1;
  end

  assign credit     = cnt_reg < DEPTH_C;
  assign req0_ready = !reset && credit && req0_valid && !grant_id;
  assign req1_ready = !reset && credit && req1_valid && grant_id;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign pop        = rsp_valid && rsp_ready;
  assign push       = stg_valid_reg;

  assign div_dividend = accept ? (grant_id ? req1_dividend : req0_dividend) : '0;
  assign div_divisor  = accept ? (grant_id ? req1_divisor : req0_divisor) : '0;
  assign dz_in        = accept && (div_divisor == '0);

  pipelinediv #(DIVIDENDLEN, DIVISORLEN) u_div (
    .clock     (clock),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  always_comb begin
    cnt_next = cnt_reg;
    if (accept && !pop)      cnt_next = cnt_reg + 1'b1;
    else if (pop && !accept) cnt_next = cnt_reg - 1'b1;
  end

  // Divide-by-zero results are forced to all-ones quotient and zero remainder.
  always_comb begin
    if (tag_dz_reg[L-1])
      stg_entry_next = {tag_id_reg[L-1], 1'b1, {DIVIDENDLEN{1'b1}}, {DIVISORLEN{1'b0}}};
    else
      stg_entry_next = {tag_id_reg[L-1], 1'b0, div_quotient, div_remainder};
  end

  // The divider carries no reset; only the tags decide what reaches the FIFO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_reg      <= 1'b1;
      cnt_reg       <= '0;
      tag_valid_reg <= '0;
      tag_id_reg    <= '0;
      tag_dz_reg    <= '0;
      stg_valid_reg <= 1'b0;
      stg_entry_reg <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      fifo_cnt_reg  <= '0;
    end else begin
      tag_valid_reg <= L'({tag_valid_reg, accept});
      tag_id_reg    <= L'({tag_id_reg, grant_id});
      tag_dz_reg    <= L'({tag_dz_reg, dz_in});
      if (accept) last_reg <= grant_id;
      cnt_reg       <= cnt_next;
      stg_valid_reg <= tag_valid_reg[L-1];
      stg_entry_reg <= stg_entry_next;
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (push && !pop)      fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
      else if (pop && !push) fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= stg_entry_reg;
  end

  assign head          = mem[rd_ptr_reg];
  assign rsp_valid     = fifo_cnt_reg != '0;
  assign rsp_id        = rsp_valid && head[EW-1];
  assign rsp_dz        = rsp_valid && head[EW-2];
  assign rsp_quotient  = rsp_valid ? head[DIVIDENDLEN+DIVISORLEN-1:DIVISORLEN] : '0;
  assign rsp_remainder = rsp_valid ? head[DIVISORLEN-1:0] : '0;
  assign busy          = cnt_reg != '0;
endmodule

// File: tb/tb_div_pipe_scheduler.sv
// Scoreboard bench for div_pipe_scheduler: accepted requests push expected
// results, a monitor pops and compares every response handshake.

module tb_div_pipe_scheduler;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_dividend = '0, req1_dividend = '0;
  logic [7:0]  req0_divisor = '0, req1_divisor = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_dz, busy;
  logic [15:0] rsp_quotient;
  logic [7:0]  rsp_remainder;

  always #5 clock = ~clock;

  div_pipe_scheduler #(.DIVIDENDLEN(16), .DIVISORLEN(8), .FIFODEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_dz(rsp_dz), .busy(busy)
  );

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dsr;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } vec_t;

  typedef struct {
    logic        id;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          acc_edge;
    bit          lat_chk;
  } exp_t;

  vec_t vecs [13];
  exp_t sb [$];
  int   q0 [$];
  int   q1 [$];
  bit   gnt_log [$];
  int   checks = 0, errors = 0, cyc = 0, acc_count = 0, rsp_count = 0;
  bit   en0 = 0, en1 = 0, lat_mode = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Driver: presents the head of each requester's list a little after every edge.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      req0_valid    = en0 && (q0.size() > 0);
      req0_dividend = (q0.size() > 0) ? vecs[q0[0]].dvd : '0;
      req0_divisor  = (q0.size() > 0) ? vecs[q0[0]].dsr : '0;
      req1_valid    = en1 && (q1.size() > 0);
      req1_dividend = (q1.size() > 0) ? vecs[q1[0]].dvd : '0;
      req1_divisor  = (q1.size() > 0) ? vecs[q1[0]].dsr : '0;
    end
  end

  // Acceptance watcher: a handshake seen here completes at the coming edge.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (req0_valid && req0_ready && q0.size() > 0) begin
        e = '{id: 1'b0, q: vecs[q0[0]].q, r: vecs[q0[0]].r, dz: vecs[q0[0]].dz,
              acc_edge: cyc + 1, lat_chk: lat_mode};
        sb.push_back(e);
        gnt_log.push_back(1'b0);
        $display("ACC id=0 %0d/%0d", vecs[q0[0]].dvd, vecs[q0[0]].dsr);
        void'(q0.pop_front());
        acc_count++;
      end
      if (req1_valid && req1_ready && q1.size() > 0) begin
        e = '{id: 1'b1, q: vecs[q1[0]].q, r: vecs[q1[0]].r, dz: vecs[q1[0]].dz,
              acc_edge: cyc + 1, lat_chk: lat_mode};
        sb.push_back(e);
        gnt_log.push_back(1'b1);
        $display("ACC id=1 %0d/%0d", vecs[q1[0]].dvd, vecs[q1[0]].dsr);
        void'(q1.pop_front());
        acc_count++;
      end
    end
  end

  // Response monitor.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && rsp_valid && rsp_ready) begin
      rsp_count++;
      $display("RSP id=%0d q=%h r=%h dz=%0d", rsp_id, rsp_quotient, rsp_remainder, rsp_dz);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp got id=%0d q=%h exp none", rsp_id, rsp_quotient);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_quotient", 32'(rsp_quotient), 32'(e.q));
        chk("rsp_remainder", 32'(rsp_remainder), 32'(e.r));
        chk("rsp_dz", 32'(rsp_dz), 32'(e.dz));
        if (e.lat_chk) chk("latency", 32'(cyc - e.acc_edge), 32'd17);
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < 400) begin
      tick(1);
      n++;
    end
    chk("drain_done", 32'(sb.size() + q0.size() + q1.size()), 32'd0);
  endtask

  initial begin
    int base, rc;
    vecs[0]  = '{16'd100,    8'd7,   16'd14,    8'd2,  1'b0};
    vecs[1]  = '{16'h1234,   8'd0,   16'hFFFF,  8'd0,  1'b1};
    vecs[2]  = '{16'd65535,  8'd255, 16'd257,   8'd0,  1'b0};
    vecs[3]  = '{16'd1000,   8'd3,   16'd333,   8'd1,  1'b0};
    vecs[4]  = '{16'd12345,  8'd100, 16'd123,   8'd45, 1'b0};
    vecs[5]  = '{16'd50000,  8'd200, 16'd250,   8'd0,  1'b0};
    vecs[6]  = '{16'd7,      8'd9,   16'd0,     8'd7,  1'b0};
    vecs[7]  = '{16'd65535,  8'd1,   16'd65535, 8'd0,  1'b0};
    vecs[8]  = '{16'd40000,  8'd123, 16'd325,   8'd25, 1'b0};
    vecs[9]  = '{16'd999,    8'd10,  16'd99,    8'd9,  1'b0};
    vecs[10] = '{16'd255,    8'd16,  16'd15,    8'd15, 1'b0};
    vecs[11] = '{16'd30000,  8'd77,  16'd389,   8'd47, 1'b0};
    vecs[12] = '{16'd0,      8'd5,   16'd0,     8'd0,  1'b0};

    // Reset state, with a requester already valid.
    q0.push_back(0);
    en0 = 1;
    tick(3);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_quotient", 32'(rsp_quotient), 32'd0);
    chk("rst_rsp_remainder", 32'(rsp_remainder), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_dz", 32'(rsp_dz), 32'd0);

    // Single request, latency and single response.
    lat_mode  = 1;
    rsp_ready = 1;
    rc        = rsp_count;
    reset     = 0;
    wait_drain();
    tick(20);
    lat_mode = 0;
    chk("single_rsp_count", 32'(rsp_count - rc), 32'd1);

    // Divide by zero from requester 1.
    q1.push_back(1);
    en1 = 1;
    wait_drain();

    // Alternating grants with both requesters valid.
    reset = 1;
    tick(2);
    gnt_log.delete();
    foreach (vecs[i]) if (i >= 2 && i <= 5) q0.push_back(i);
    foreach (vecs[i]) if (i >= 6 && i <= 9) q1.push_back(i);
    reset = 0;
    wait_drain();
    chk("grant_count", 32'(gnt_log.size()), 32'd8);
    for (int i = 0; i < gnt_log.size(); i++) chk("grant_order", 32'(gnt_log[i]), 32'(i % 2));

    // Credit limit with the consumer stalled.
    rsp_ready = 0;
    base = acc_count;
    q0.push_back(10); q0.push_back(11); q0.push_back(12); q0.push_back(3);
    q1.push_back(4);  q1.push_back(5);  q1.push_back(6);  q1.push_back(7);
    tick(30);
    chk("credit_accepts", 32'(acc_count - base), 32'd4);
    chk("credit_ready0", 32'(req0_ready), 32'd0);
    chk("credit_ready1", 32'(req1_ready), 32'd0);
    chk("credit_busy", 32'(busy), 32'd1);
    chk("credit_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1;
    tick(1);
    rsp_ready = 0;
    chk("pop_frees_credit", 32'(req0_ready | req1_ready), 32'd1);
    tick(1);
    chk("one_more_accept", 32'(acc_count - base), 32'd5);
    chk("ready_after_refill", 32'(req0_ready | req1_ready), 32'd0);
    tick(5);
    chk("no_extra_accept", 32'(acc_count - base), 32'd5);

    // Full FIFO: pop, then pop and accept together, then accept.
    tick(20);
    chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1;
    tick(2);
    rsp_ready = 0;
    chk("pop_accept_same_cycle", 32'(acc_count - base), 32'd6);
    chk("pop_accept_busy", 32'(busy), 32'd1);
    tick(1);
    chk("refill_to_limit", 32'(acc_count - base), 32'd7);
    chk("refill_ready", 32'(req0_ready | req1_ready), 32'd0);
    rsp_ready = 1;
    wait_drain();

    // Reset with one buffered and three in flight.
    rsp_ready = 0;
    q0.push_back(0);
    tick(22);
    chk("buffered_rsp_valid", 32'(rsp_valid), 32'd1);
    q0.push_back(2); q0.push_back(3); q1.push_back(4);
    tick(5);
    chk("pre_reset_accepts", 32'(sb.size()), 32'd4);
    reset = 1;
    #1;
    chk("mid_reset_busy", 32'(busy), 32'd0);
    chk("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    sb.delete();
    q0.delete();
    q1.delete();
    en0 = 0;
    en1 = 0;
    tick(2);
    reset     = 0;
    rsp_ready = 1;
    rc        = rsp_count;
    tick(40);
    chk("no_stale_rsp", 32'(rsp_count - rc), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
